reg_file_scoreboard: RTL and testbench

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

---
 rtl/reg_file_scoreboard.sv | 80 ++++++++
 tb/tb_reg_file_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register busy (pending producer) tracking, write-to-read
// bypass and a running count of pending registers. Register 0 is hardwired to zero.
module reg_file_scoreboard #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] readAddr,
    input  logic [NUM_RD-1:0]        readEnable,
    output logic [NUM_RD*XLEN-1:0]   readData,
    input  logic                     regWrite,
    input  logic [ADDR_W-1:0]        writeRegister,
    input  logic [XLEN-1:0]          writeData,
    input  logic                     reserve,
    input  logic [ADDR_W-1:0]        reserveRegister,
    output logic [NUM_RD-1:0]        readBusy,
    output logic                     hazard,
    output logic [ADDR_W:0]          busyCount
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_busy_count;

    logic             w_wr_en;
    logic             w_rsv_en;
    logic             w_set;
    logic             w_clr;
    logic [NREGS-1:0] w_busy_next;

    // Gating with rst also suppresses the bypass path while reset is held.
    assign w_wr_en  = regWrite && (writeRegister != '0) && !rst;
    assign w_rsv_en = reserve && (reserveRegister != '0) && !rst;

    // A reserve landing on the register being written keeps it busy: net count 0 if it was busy.
    assign w_set = w_rsv_en && !r_busy[reserveRegister];
    assign w_clr = w_wr_en && r_busy[writeRegister] &&
                   !(w_rsv_en && (reserveRegister == writeRegister));

    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en)
            w_busy_next[writeRegister] = 1'b0;
        if (w_rsv_en)
            w_busy_next[reserveRegister] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_en)
                r_regs[writeRegister] <= writeData;
            r_busy       <= w_busy_next;
            r_busy_count <= r_busy_count + CW'(w_set) - CW'(w_clr);
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_bypass;

        assign w_addr   = readAddr[g*ADDR_W +: ADDR_W];
        assign w_bypass = w_wr_en && (writeRegister == w_addr);
        assign readData[g*XLEN +: XLEN] = w_bypass ? writeData : r_regs[w_addr];
        assign readBusy[g] = r_busy[w_addr] && !w_bypass;
    end

    assign hazard    = |(readBusy & readEnable);
    assign busyCount = r_busy_count;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed vector table, asynchronous
// reset sequence, then randomized traffic against an array-based reference model.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst;
    logic [9:0]  readAddr;
    logic [1:0]  readEnable;
    logic [63:0] readData;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        reserve;
    logic [4:0]  reserveRegister;
    logic [1:0]  readBusy;
    logic        hazard;
    logic [5:0]  busyCount;

    int n_checks = 0;
    int n_pass   = 0;

    reg_file_scoreboard #(.XLEN(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .readAddr       (readAddr),
        .readEnable     (readEnable),
        .readData       (readData),
        .regWrite       (regWrite),
        .writeRegister  (writeRegister),
        .writeData      (writeData),
        .reserve        (reserve),
        .reserveRegister(reserveRegister),
        .readBusy       (readBusy),
        .hazard         (hazard),
        .busyCount      (busyCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  rr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [1:0]  ren;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        eh;
        logic [5:0]  ec;
    } vec_t;

    vec_t tbl [16];

    // reference model state
    logic [31:0] m_reg  [32];
    logic [31:0] m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [1:0] eb, input logic eh, input logic [5:0] ec);
        chk({tag, " readData0"}, readData[31:0], e0);
        chk({tag, " readData1"}, readData[63:32], e1);
        chk({tag, " readBusy"}, {30'd0, readBusy}, {30'd0, eb});
        chk({tag, " hazard"}, {31'd0, hazard}, {31'd0, eh});
        chk({tag, " busyCount"}, {26'd0, busyCount}, {26'd0, ec});
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic rsv, input logic [4:0] rr, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [1:0] ren);
        regWrite        = we;
        writeRegister   = wr;
        writeData       = wd;
        reserve         = rsv;
        reserveRegister = rr;
        readAddr        = {a1, a0};
        readEnable      = ren;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0)
            return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    initial begin
        //            we  wr     wd            rsv  rr    a0    a1    ren    e0            e1            eb     eh    ec
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0, 6'd0};
        tbl[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 32'h0,        32'h0,        2'b00, 1'b0, 6'd0};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 2'b11, 32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 6'd0};
        tbl[4]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0, 5'd7, 5'd5, 2'b11, 32'h12345678, 32'hDEADBEEF, 2'b00, 1'b0, 6'd0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3, 5'd7, 2'b00, 32'h0,        32'h12345678, 2'b00, 1'b0, 6'd0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 5'd3, 5'd4, 2'b01, 32'h0,        32'h0,        2'b01, 1'b1, 6'd1};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 2'b11, 32'h0,        32'h0,        2'b11, 1'b1, 6'd2};
        tbl[8]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd4, 2'b01, 32'hA5A5A5A5, 32'h0,        2'b10, 1'b0, 6'd2};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 2'b00, 32'hA5A5A5A5, 32'h0,        2'b10, 1'b0, 6'd1};
        tbl[10] = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd9, 5'd9, 5'd4, 2'b00, 32'h00000099, 32'h0,        2'b10, 1'b0, 6'd1};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9, 5'd4, 2'b00, 32'h00000099, 32'h0,        2'b11, 1'b0, 6'd2};
        tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd4, 2'b10, 32'h00000099, 32'h0,        2'b11, 1'b1, 6'd2};
        tbl[13] = '{1'b1, 5'd4,  32'h00000044, 1'b0, 5'd0, 5'd9, 5'd4, 2'b11, 32'h00000099, 32'h00000044, 2'b01, 1'b1, 6'd2};
        tbl[14] = '{1'b1, 5'd12, 32'h0000000C, 1'b0, 5'd0, 5'd12, 5'd4, 2'b11, 32'h0000000C, 32'h00000044, 2'b00, 1'b0, 6'd1};
        tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd12, 2'b11, 32'h00000099, 32'h0000000C, 2'b01, 1'b1, 6'd1};

        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7, 2'b11);
        #1;
        check_all("reset", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].rsv, tbl[i].rr,
                  tbl[i].a0, tbl[i].a1, tbl[i].ren);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].eb, tbl[i].eh, tbl[i].ec);
            @(posedge clk);
            #1;
        end

        // Reserve x20 to reach two pending registers, then hit reset between clock edges.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd9, 5'd20, 2'b11);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd20, 2'b11);
        @(negedge clk);
        check_all("pre_rst", 32'h00000099, 32'h0, 2'b11, 1'b1, 6'd2);
        #2;
        drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd21, 5'd5, 5'd9, 2'b11);
        rst = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd21, 2'b11);
        @(negedge clk);
        check_all("post_rst", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd20, 2'b11);
        #1;
        check_all("post_rst2", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 32; k++)
            m_reg[k] = 32'h0;
        m_busy = 32'h0;

        for (int c = 0; c < 400; c++) begin
            logic        r_rst;
            logic        we, rsv;
            logic [4:0]  wr, rr, a0, a1;
            logic [31:0] wd, e0, e1;
            logic [1:0]  ren, eb;
            logic        byp0, byp1;

            r_rst = ($urandom_range(0, 39) == 0);
            we    = ($urandom_range(0, 2) == 0);
            rsv   = ($urandom_range(0, 2) == 0);
            wr    = rand_addr();
            rr    = rand_addr();
            a0    = rand_addr();
            a1    = rand_addr();
            wd    = $urandom;
            ren   = 2'($urandom_range(0, 3));
            drive(we, wr, wd, rsv, rr, a0, a1, ren);
            rst = r_rst;

            if (r_rst) begin
                e0 = 32'h0;
                e1 = 32'h0;
                eb = 2'b00;
            end else begin
                byp0  = we && (wr != 0) && (wr == a0);
                byp1  = we && (wr != 0) && (wr == a1);
                e0    = byp0 ? wd : m_reg[a0];
                e1    = byp1 ? wd : m_reg[a1];
                eb[0] = m_busy[a0] && !byp0;
                eb[1] = m_busy[a1] && !byp1;
            end
            @(negedge clk);
            check_all($sformatf("rnd%0d", c), e0, e1, eb, |(eb & ren),
                      r_rst ? 6'd0 : 6'($countones(m_busy)));
            @(posedge clk);
            #1;
            if (r_rst) begin
                for (int k = 0; k < 32; k++)
                    m_reg[k] = 32'h0;
                m_busy = 32'h0;
            end else begin
                if (we && wr != 0) begin
                    m_reg[wr]  = wd;
                    m_busy[wr] = 1'b0;
                end
                if (rsv && rr != 0)
                    m_busy[rr] = 1'b1;
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
